// File: rtl/ntt_pass_sequencer.sv
// Pass-level controller for the NTT butterfly address generator: sequences
// newloop pulses, counts passes, and watches each pass with a cycle watchdog.
module ntt_pass_sequencer #(
    parameter int unsigned LAYERS          = 7,
    parameter int unsigned LOOPS_PER_LAYER = 3,
    parameter int unsigned IO_PASS_CYCLES  = 260,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       ctr_sig,
    output logic [1:0] mode,
    output logic       newloop,
    output logic       busy,
    output logic [4:0] pass_cnt,
    output logic       done,
    output logic       error
);

    localparam int unsigned PASS_W      = 5;
    localparam int unsigned RUN_W       = 12;
    localparam int unsigned NTT_PASSES  = 1 + LAYERS * LOOPS_PER_LAYER;
    localparam int unsigned SET_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned IO_LAST     = IO_PASS_CYCLES - 1;
    localparam int unsigned TO_LAST     = TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SETTLE,
        FIN
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          mode_nxt;
    logic                newloop_nxt;
    logic                busy_nxt;
    logic [PASS_W-1:0]   pass_cnt_nxt;
    logic                done_nxt;
    logic                error_nxt;
    // One RUN-cycle counter serves as both pass timer and watchdog: both
    // clear in LOAD and advance on every RUN cycle.
    logic [RUN_W-1:0]    run_cnt, run_cnt_nxt;
    logic [SET_W-1:0]    settle_cnt, settle_cnt_nxt;
    logic                ctr_sig_d;

    logic                ctr_rise;
    logic                pass_end;
    logic                final_pass;
    logic                timeout;
    logic                settle_last;
    logic [PASS_W-1:0]   pass_target;

    // Pass-end, timeout and settle decode from the current registered state.
    always_comb begin
        ctr_rise    = ctr_sig & ~ctr_sig_d;
        pass_end    = mode[1] ? (run_cnt == RUN_W'(IO_LAST)) : ctr_rise;
        pass_target = mode[1] ? PASS_W'(1) : PASS_W'(NTT_PASSES);
        final_pass  = (pass_cnt + PASS_W'(1)) == pass_target;
        timeout     = run_cnt == RUN_W'(TO_LAST);
        settle_last = (SETTLE_CYCLES <= 1) || (settle_cnt == SET_W'(SETTLE_LAST));
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode;
        newloop_nxt    = 1'b0;
        busy_nxt       = busy;
        pass_cnt_nxt   = pass_cnt;
        done_nxt       = 1'b0;
        error_nxt      = error;
        run_cnt_nxt    = run_cnt;
        settle_cnt_nxt = settle_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = LOAD;
                    mode_nxt     = op;
                    busy_nxt     = 1'b1;
                    error_nxt    = 1'b0;
                    pass_cnt_nxt = '0;
                    newloop_nxt  = 1'b1;
                end
            end
            LOAD: begin
                state_nxt   = RUN;
                run_cnt_nxt = '0;
            end
            RUN: begin
                run_cnt_nxt = run_cnt + RUN_W'(1);
                if (pass_end) begin
                    pass_cnt_nxt = pass_cnt + PASS_W'(1);
                    if (final_pass) begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt      = SETTLE;
                        settle_cnt_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    state_nxt   = LOAD;
                    newloop_nxt = 1'b1;
                end else begin
                    settle_cnt_nxt = settle_cnt + SET_W'(1);
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, output and counter registers. ctr_sig_d tracks ctr_sig in every
    // state, so a level still high from the previous pass reads as old.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= 2'b00;
            newloop    <= 1'b0;
            busy       <= 1'b0;
            pass_cnt   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            run_cnt    <= '0;
            settle_cnt <= '0;
            ctr_sig_d  <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            newloop    <= newloop_nxt;
            busy       <= busy_nxt;
            pass_cnt   <= pass_cnt_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            run_cnt    <= run_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            ctr_sig_d  <= ctr_sig;
        end
    end

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Directed bench for ntt_pass_sequencer with hand-computed expectations.
module tb_ntt_pass_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       ctr_sig;
    logic [1:0] mode;
    logic       newloop;
    logic       busy;
    logic [4:0] pass_cnt;
    logic       done;
    logic       error;

    int n_cmp;
    int n_err;
    int nl_cnt;
    int done_cnt;
    int nl_back2back;
    bit prev_nl;
    int gap;
    int cyc;

    ntt_pass_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .ctr_sig  (ctr_sig),
        .mode     (mode),
        .newloop  (newloop),
        .busy     (busy),
        .pass_cnt (pass_cnt),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (newloop === 1'b1) begin
            nl_cnt++;
            if (prev_nl) nl_back2back++;
        end
        if (done === 1'b1) done_cnt++;
        prev_nl = (newloop === 1'b1);
    endtask

    task automatic clear_counts();
        nl_cnt   = 0;
        done_cnt = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; nl_back2back = 0; prev_nl = 1'b0;
        clear_counts();
        rst = 1'b1; start = 1'b0; op = 2'b00; ctr_sig = 1'b0;

        // Reset state
        step(); step();
        rst = 1'b0;
        check_eq("rst_mode", 32'(mode), 0);
        check_eq("rst_newloop", 32'(newloop), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_pass_cnt", 32'(pass_cnt), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_error", 32'(error), 0);

        // Test 1 / 6: reset mid-RUN, with start coincident with rst
        start = 1'b1; op = 2'b00;
        step();
        start = 1'b0;
        check_eq("t1_nl_latency", 32'(newloop), 1);
        check_eq("t1_busy", 32'(busy), 1);
        repeat (5) step();
        ctr_sig = 1'b1;
        step();
        ctr_sig = 1'b0;
        check_eq("t1_pass_cnt", 32'(pass_cnt), 1);
        step();
        check_eq("t1_settle0", 32'(newloop), 0);
        step();
        check_eq("t1_settle_nl", 32'(newloop), 1);
        repeat (5) step();
        rst = 1'b1; start = 1'b1; op = 2'b11;
        clear_counts();
        step();
        check_eq("t1_rst_outs", 32'({mode, newloop, busy, pass_cnt, done, error}), 0);
        step(); step();
        rst = 1'b0; start = 1'b0;
        repeat (3) step();
        check_eq("t1_post_busy", 32'(busy), 0);
        check_eq("t1_post_mode", 32'(mode), 0);
        check_eq("t1_post_nl", 32'(nl_cnt), 0);
        check_eq("t1_post_done", 32'(done_cnt), 0);

        // Test 2: full NTT, ctr_sig pulsed 400 cycles after each newloop
        clear_counts();
        start = 1'b1; op = 2'b00;
        step();
        start = 1'b0;
        for (int p = 0; p < 22; p++) begin
            check_eq("t2_newloop", 32'(newloop), 1);
            check_eq("t2_mode", 32'(mode), 0);
            check_eq("t2_pass_cnt_at_nl", 32'(pass_cnt), 32'(p));
            repeat (400) step();
            ctr_sig = 1'b1;
            step();
            ctr_sig = 1'b0;
            if (p < 21) begin
                gap = 1;
                while (newloop !== 1'b1 && gap < 20) begin
                    step();
                    gap++;
                end
                check_eq("t2_gap", 32'(gap), 3);
            end else begin
                check_eq("t2_done", 32'(done), 1);
                check_eq("t2_busy_end", 32'(busy), 0);
            end
        end
        repeat (5) step();
        check_eq("t2_done_once", 32'(done_cnt), 1);
        check_eq("t2_nl_total", 32'(nl_cnt), 22);
        check_eq("t2_pass_final", 32'(pass_cnt), 22);
        check_eq("t2_mode_end", 32'(mode), 0);

        // Test 3: IN load, ctr_sig toggling is ignored, done 261 cycles after start
        clear_counts();
        start = 1'b1; op = 2'b10;
        step();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            ctr_sig = ~ctr_sig;
            step();
            cyc++;
        end
        ctr_sig = 1'b0;
        check_eq("t3_done_latency", 32'(cyc), 261);
        check_eq("t3_nl_count", 32'(nl_cnt), 1);
        check_eq("t3_pass_cnt", 32'(pass_cnt), 1);
        check_eq("t3_mode", 32'(mode), 2);
        check_eq("t3_busy", 32'(busy), 0);
        repeat (3) step();

        // Test 4: INTT with ctr_sig held high across a newloop
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0;
        repeat (5) step();
        ctr_sig = 1'b1;
        step();
        check_eq("t4_first_end", 32'(pass_cnt), 1);
        step(); step();
        check_eq("t4_newloop", 32'(newloop), 1);
        repeat (20) step();
        check_eq("t4_held_level", 32'(pass_cnt), 1);
        ctr_sig = 1'b0;
        step(); step();
        ctr_sig = 1'b1;
        step();
        ctr_sig = 1'b0;
        check_eq("t4_new_edge", 32'(pass_cnt), 2);
        check_eq("t4_mode", 32'(mode), 1);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Test 5: watchdog expires after 4095 RUN cycles
        clear_counts();
        start = 1'b1; op = 2'b00;
        step();
        start = 1'b0;
        repeat (4095) step();
        check_eq("t5_error_early", 32'(error), 0);
        check_eq("t5_busy_early", 32'(busy), 1);
        step();
        check_eq("t5_error", 32'(error), 1);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_no_done", 32'(done_cnt), 0);
        repeat (3) step();
        check_eq("t5_error_sticky", 32'(error), 1);

        // Test 6: new start clears error; starts while busy are ignored
        clear_counts();
        start = 1'b1; op = 2'b10;
        step();
        start = 1'b0;
        check_eq("t6_error_clr", 32'(error), 0);
        check_eq("t6_mode", 32'(mode), 2);
        start = 1'b1; op = 2'b11;
        step();
        start = 1'b0;
        repeat (10) step();
        start = 1'b1; op = 2'b01;
        step();
        start = 1'b0;
        check_eq("t6_mode_hold", 32'(mode), 2);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        check_eq("t6_done_seen", 32'(done), 1);
        repeat (3) step();
        check_eq("t6_nl_count", 32'(nl_cnt), 1);
        check_eq("t6_done_count", 32'(done_cnt), 1);
        check_eq("t6_mode_end", 32'(mode), 2);

        check_eq("newloop_back2back", 32'(nl_back2back), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
